// File: rtl/rr_req_agent_if.sv
// Request/grant bus between the requester agent and the round-robin arbiter.
// The agent drives r and samples g; the arbiter does the opposite.
interface rr_req_agent_if;
  logic [3:0] r;
  logic [3:0] g;

  modport master (output r, input g);
  modport slave  (input r, output g);
endinterface

// File: rtl/rr_req_agent.sv
// Requester-side agent for a 4-way round-robin arbiter: per-port pending job
// counters drive the request lines; each accepted grant retires one job.
module rr_req_agent #(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          inc,
  rr_req_agent_if.master      arb,
  output logic                svc_valid,
  output logic [1:0]          svc_id,
  output logic                pend_any,
  output logic [3:0]          overflow,
  output logic [3:0]          starve,
  output logic                gnt_err
);

  // Bus semantics: r is a level request held while jobs remain; g is a
  // registered grant from the arbiter. A grant is accepted only when it is
  // one-hot and targets a port with pending work; that accepted grant
  // retires exactly one job in the same cycle.

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  pend     [4];
  logic [CNT_W-1:0]  pend_nxt [4];
  logic [WAIT_W-1:0] wcnt     [4];
  logic [WAIT_W-1:0] wcnt_nxt [4];

  logic [3:0] nz;
  logic [3:0] acc;
  logic [3:0] req;
  logic [3:0] ovf_set;
  logic [3:0] stv_set;
  logic       g_onehot;
  logic       err_set;
  logic       svc_nxt;
  logic [1:0] id_nxt;

  assign g_onehot = (arb.g != 4'd0) && ((arb.g & (arb.g - 4'd1)) == 4'd0);
  assign arb.r    = req;
  assign pend_any = |nz;

  always_comb begin
    nz      = '0;
    acc     = '0;
    req     = '0;
    ovf_set = '0;
    stv_set = '0;
    for (int i = 0; i < 4; i++) begin
      pend_nxt[i] = pend[i];
      wcnt_nxt[i] = wcnt[i];
      nz[i]  = (pend[i] != '0);
      acc[i] = arb.g[i] & nz[i] & g_onehot;
      // Lookahead: drop the request in the cycle its last job is granted.
      req[i] = (pend[i] > CNT_W'(1)) | ((pend[i] == CNT_W'(1)) & ~acc[i]);

      case ({inc[i], acc[i]})
        2'b10: begin
          if (pend[i] == CNT_MAX) ovf_set[i] = 1'b1;
          else                    pend_nxt[i] = pend[i] + CNT_W'(1);
        end
        2'b01:   pend_nxt[i] = pend[i] - CNT_W'(1);
        default: pend_nxt[i] = pend[i];
      endcase

      if (!nz[i] || acc[i])        wcnt_nxt[i] = '0;
      else if (wcnt[i] != WAIT_SAT) wcnt_nxt[i] = wcnt[i] + WAIT_W'(1);
      stv_set[i] = (wcnt_nxt[i] == WAIT_SAT);
    end

    err_set = ((arb.g != 4'd0) && !g_onehot) || (g_onehot && ((arb.g & ~nz) != 4'd0));

    svc_nxt = |acc;
    case (acc)
      4'b0010: id_nxt = 2'd1;
      4'b0100: id_nxt = 2'd2;
      4'b1000: id_nxt = 2'd3;
      default: id_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pend[i] <= '0;
        wcnt[i] <= '0;
      end
      svc_valid <= 1'b0;
      svc_id    <= 2'd0;
      overflow  <= '0;
      starve    <= '0;
      gnt_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pend[i] <= pend_nxt[i];
        wcnt[i] <= wcnt_nxt[i];
      end
      svc_valid <= svc_nxt;
      if (svc_nxt) svc_id <= id_nxt;
      overflow  <= overflow | ovf_set;
      starve    <= starve | stv_set;
      gnt_err   <= gnt_err | err_set;
    end
  end

endmodule

// File: tb/tb_rr_req_agent.sv
// Self-checking bench for rr_req_agent: vector table, directed corner cases,
// then randomized traffic against a job-count reference model.
module tb_rr_req_agent;

  logic       clk;
  logic       reset;
  logic [3:0] inc;
  logic       svc_valid;
  logic [1:0] svc_id;
  logic       pend_any;
  logic [3:0] overflow;
  logic [3:0] starve;
  logic       gnt_err;

  rr_req_agent_if arb ();

  rr_req_agent #(.CNT_W(4), .MAX_WAIT(16), .WAIT_W(5)) dut (
    .clk(clk), .reset(reset), .inc(inc), .arb(arb),
    .svc_valid(svc_valid), .svc_id(svc_id), .pend_any(pend_any),
    .overflow(overflow), .starve(starve), .gnt_err(gnt_err)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;

  int   m_pend [4];
  int   m_wait [4];
  bit   m_ovf  [4];
  bit   m_stv  [4];
  bit   m_err;
  bit   m_sv;
  logic [1:0] exp_q[$];

  logic [3:0] cur_inc;
  logic [3:0] cur_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_wait[i] = 0; m_ovf[i] = 0; m_stv[i] = 0;
    end
    m_err = 0;
    m_sv  = 0;
    exp_q.delete();
  endfunction

  function automatic bit granted(input int i, input logic [3:0] gg);
    return ($countones(gg) == 1) && gg[i] && (m_pend[i] > 0);
  endfunction

  function automatic void model_step(input logic [3:0] ii, input logic [3:0] gg);
    bit a;
    m_sv = 0;
    if ($countones(gg) > 1) m_err = 1;
    for (int i = 0; i < 4; i++) begin
      a = granted(i, gg);
      if (gg[i] && $countones(gg) == 1 && m_pend[i] == 0) m_err = 1;
      if (a) begin
        m_sv = 1;
        exp_q.push_back(2'(i));
      end
      if (m_pend[i] == 0 || a) m_wait[i] = 0;
      else if (m_wait[i] < 16) m_wait[i]++;
      if (m_wait[i] == 16) m_stv[i] = 1;
      if (ii[i] && !a) begin
        if (m_pend[i] == 15) m_ovf[i] = 1;
        else m_pend[i]++;
      end else if (a && !ii[i]) begin
        m_pend[i]--;
      end
    end
  endfunction

  task automatic check_model();
    logic [3:0] er, eo, es;
    logic [1:0] eid;
    bit ea;
    ea = 0;
    for (int i = 0; i < 4; i++) begin
      // Request stays up while jobs remain after this cycle's acceptance.
      er[i] = (m_pend[i] - int'(granted(i, cur_g))) > 0;
      eo[i] = m_ovf[i];
      es[i] = m_stv[i];
      if (m_pend[i] != 0) ea = 1;
    end
    chk("r", {28'd0, arb.r}, {28'd0, er});
    chk("pend_any", {31'd0, pend_any}, {31'd0, ea});
    chk("svc_valid", {31'd0, svc_valid}, {31'd0, m_sv});
    if (m_sv) begin
      if (exp_q.size() == 0) chk("svc_q_empty", 32'd1, 32'd0);
      else begin
        eid = exp_q.pop_front();
        chk("svc_id", {30'd0, svc_id}, {30'd0, eid});
      end
    end
    chk("overflow", {28'd0, overflow}, {28'd0, eo});
    chk("starve", {28'd0, starve}, {28'd0, es});
    chk("gnt_err", {31'd0, gnt_err}, {31'd0, m_err});
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [3:0] ii, input logic [3:0] gg);
    @(negedge clk);
    inc = ii; arb.g = gg;
    cur_inc = ii; cur_g = gg;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(cur_inc, cur_g);
  endtask

  task automatic step(input logic [3:0] ii, input logic [3:0] gg);
    apply(ii, gg);
    tick();
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    inc = 4'd0; arb.g = 4'd0; cur_inc = 4'd0; cur_g = 4'd0;
    #2 reset = 1'b1;
    #1;
    chk("rst_r", {28'd0, arb.r}, 32'd0);
    chk("rst_svc", {31'd0, svc_valid}, 32'd0);
    chk("rst_flags", {19'd0, overflow, starve, gnt_err, pend_any}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] inc;
    logic [3:0] g;
    logic [3:0] r;
    logic       pa;
    logic       sv;
    logic [1:0] sid;
    logic       err;
  } vec_t;

  vec_t vt [16];

  initial begin
    int npend;
    int plist [4];
    int rsel;
    logic [3:0] ri, rg;

    vt[0]  = '{4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0};
    vt[1]  = '{4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0};
    vt[2]  = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0};
    vt[3]  = '{4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0};
    vt[4]  = '{4'b0000, 4'b0001, 4'b1110, 1, 0, 0, 0};
    vt[5]  = '{4'b0000, 4'b0010, 4'b1100, 1, 1, 0, 0};
    vt[6]  = '{4'b0000, 4'b0100, 4'b1000, 1, 1, 1, 0};
    vt[7]  = '{4'b0000, 4'b1000, 4'b0000, 1, 1, 2, 0};
    vt[8]  = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 3, 0};
    vt[9]  = '{4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0};
    vt[10] = '{4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 0};
    vt[11] = '{4'b0000, 4'b0000, 4'b0100, 1, 1, 2, 0};
    vt[12] = '{4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 0};
    vt[13] = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 2, 0};
    vt[14] = '{4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0};
    vt[15] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 1};

    reset = 1'b1; inc = 4'd0; arb.g = 4'd0; cur_inc = 4'd0; cur_g = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", {18'd0, arb.r, svc_valid, overflow, starve, gnt_err, pend_any}, 32'd0);
    reset = 1'b0;

    // Table: single job, round robin, inc with grant, stale grant.
    for (int k = 0; k < 16; k++) begin
      apply(vt[k].inc, vt[k].g);
      chk($sformatf("vec%0d_r", k), {28'd0, arb.r}, {28'd0, vt[k].r});
      chk($sformatf("vec%0d_pa", k), {31'd0, pend_any}, {31'd0, vt[k].pa});
      chk($sformatf("vec%0d_sv", k), {31'd0, svc_valid}, {31'd0, vt[k].sv});
      if (vt[k].sv) chk($sformatf("vec%0d_id", k), {30'd0, svc_id}, {30'd0, vt[k].sid});
      chk($sformatf("vec%0d_err", k), {31'd0, gnt_err}, {31'd0, vt[k].err});
      tick();
    end

    // Overflow: 16 pulses saturate at 15, then 15 grants drain it exactly.
    async_reset();
    repeat (16) step(4'b0010, 4'b0000);
    apply(4'b0000, 4'b0000);
    chk("ovf_flag", {31'd0, overflow[1]}, 32'd1);
    chk("ovf_req", {31'd0, arb.r[1]}, 32'd1);
    tick();
    repeat (14) step(4'b0000, 4'b0010);
    apply(4'b0000, 4'b0000);
    chk("ovf_14_left", {31'd0, arb.r[1]}, 32'd1);
    chk("ovf_sticky", {31'd0, overflow[1]}, 32'd1);
    tick();
    step(4'b0000, 4'b0010);
    apply(4'b0000, 4'b0000);
    chk("ovf_drained", {31'd0, pend_any}, 32'd0);
    tick();

    // Starvation then a multi-hot grant.
    async_reset();
    step(4'b1000, 4'b0000);
    repeat (15) step(4'b0000, 4'b0000);
    apply(4'b0000, 4'b0000);
    chk("stv_before", {31'd0, starve[3]}, 32'd0);
    tick();
    apply(4'b0000, 4'b0000);
    chk("stv_set", {31'd0, starve[3]}, 32'd1);
    tick();
    step(4'b0000, 4'b0011);
    apply(4'b0000, 4'b0000);
    chk("mh_err", {31'd0, gnt_err}, 32'd1);
    chk("mh_nosvc", {31'd0, svc_valid}, 32'd0);
    chk("mh_req3", {31'd0, arb.r[3]}, 32'd1);
    tick();

    // Reset mid-operation with pend = {2,1,0,3}, then a stale grant.
    async_reset();
    step(4'b1101, 4'b0000);
    step(4'b1001, 4'b0000);
    step(4'b0001, 4'b0000);
    apply(4'b0000, 4'b0000);
    chk("mid_r", {28'd0, arb.r}, 32'hd);
    tick();
    async_reset();
    step(4'b0000, 4'b0001);
    apply(4'b0000, 4'b0000);
    chk("post_rst_err", {31'd0, gnt_err}, 32'd1);
    chk("post_rst_nosvc", {31'd0, svc_valid}, 32'd0);
    tick();

    // Randomized traffic against the model.
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        ri = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        rsel = $urandom_range(0, 19);
        rg = 4'd0;
        if (rsel >= 6 && rsel <= 18) begin
          npend = 0;
          for (int i = 0; i < 4; i++) if (m_pend[i] > 0) begin plist[npend] = i; npend++; end
          if (npend > 0) rg = 4'b0001 << plist[$urandom_range(0, npend - 1)];
        end else if (rsel == 19) begin
          rg = 4'($urandom_range(0, 15));
        end
        step(ri, rg);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
